// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Sequential load/store unit between the M-stage pipeline and a
//   variable-latency req/ack data bus. One access in flight at a time.
//   Alignment is checked on acceptance. Bus transactions time out to a
//   bus-error exception. Loads return lane-selected, zero- or
//   sign-extended data.
//
// Ports
//   clk, reset             clock (rising edge), async active-high reset
//   req_valid/op/addr/wdata pipeline access request; req_ready = idle
//   flush                  cancels acceptance / response of current access
//   resp_valid/rdata/exc/exccode  one-cycle completion pulse
//   bus_req/we/addr/be/wdata      bus request, held until bus_ack
//   bus_ack/rdata          bus completion and read data
module mem_access_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [3:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  output logic                req_ready,
  input  logic                flush,
  output logic                resp_valid,
  output logic [31:0]         resp_rdata,
  output logic                resp_exc,
  output logic [4:0]          resp_exccode,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned LW = $clog2(NB);
  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] AMASK = {ADDR_W{1'b1}} << LW;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0, OP_LW  = 4'd1, OP_LBU = 4'd2, OP_LB = 4'd3,
    OP_LHU  = 4'd4, OP_LH  = 4'd5, OP_SW  = 4'd6, OP_SB = 4'd7,
    OP_SH   = 4'd8
  } op_t;

  state_t              state_q;
  logic [3:0]          op_q;
  logic [LW-1:0]       lane_q;
  logic [CW-1:0]       cnt_q;
  logic                cancel_q;
  logic                bus_req_q, bus_we_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic [NB-1:0]       bus_be_q;
  logic [DATA_W-1:0]   bus_wdata_q;
  logic                resp_valid_q, resp_exc_q;
  logic [4:0]          resp_exccode_q;
  logic [31:0]         resp_rdata_q;

  // Request decode
  logic                op_valid, is_load, is_store, is_word, is_half, misaligned;
  logic [LW-1:0]       lane;
  logic [NB-1:0]       be_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [ADDR_W-1:0]   addr_d;

  always_comb begin
    is_load    = (req_op >= OP_LW) && (req_op <= OP_LH);
    is_store   = (req_op >= OP_SW) && (req_op <= OP_SH);
    op_valid   = is_load || is_store;
    is_word    = (req_op == OP_LW) || (req_op == OP_SW);
    is_half    = (req_op == OP_LHU) || (req_op == OP_LH) || (req_op == OP_SH);
    misaligned = (is_word && (req_addr[1:0] != 2'b00)) || (is_half && req_addr[0]);
    lane       = req_addr[LW-1:0];
    addr_d     = req_addr & AMASK;
    be_d       = '0;
    wdata_d    = '0;
    if (is_store) begin
      if (is_word) begin
        be_d    = NB'(4'hF) << lane;
        wdata_d = {(NB/4){req_wdata}};
      end else if (is_half) begin
        be_d    = NB'(2'b11) << lane;
        wdata_d = {(NB/2){req_wdata[15:0]}};
      end else begin
        be_d    = NB'(1'b1) << lane;
        wdata_d = {NB{req_wdata[7:0]}};
      end
    end
  end

  // Load extension of the lane addressed by the latched access
  logic [DATA_W-1:0]   shifted;
  logic [31:0]         ext_d;

  always_comb begin
    shifted = bus_rdata >> {lane_q, 3'b000};
    ext_d   = '0;
    case (op_q)
      OP_LW:   ext_d = shifted[31:0];
      OP_LBU:  ext_d = {24'b0, shifted[7:0]};
      OP_LB:   ext_d = {{24{shifted[7]}}, shifted[7:0]};
      OP_LHU:  ext_d = {16'b0, shifted[15:0]};
      OP_LH:   ext_d = {{16{shifted[15]}}, shifted[15:0]};
      default: ext_d = '0;
    endcase
  end

  // Ack takes priority over the timeout in the same cycle.
  logic timeout_hit;
  always_comb begin
    timeout_hit = (TIMEOUT != 0) && !bus_ack && (cnt_q == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      op_q           <= '0;
      lane_q         <= '0;
      cnt_q          <= '0;
      cancel_q       <= 1'b0;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_be_q       <= '0;
      bus_wdata_q    <= '0;
      resp_valid_q   <= 1'b0;
      resp_exc_q     <= 1'b0;
      resp_exccode_q <= '0;
      resp_rdata_q   <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && !flush && op_valid) begin
            op_q     <= req_op;
            lane_q   <= lane;
            cnt_q    <= '0;
            cancel_q <= 1'b0;
            if (misaligned) begin
              state_q        <= RESP;
              resp_valid_q   <= 1'b1;
              resp_exc_q     <= 1'b1;
              resp_exccode_q <= is_store ? 5'd5 : 5'd4;
              resp_rdata_q   <= '0;
            end else begin
              state_q     <= BUS;
              bus_req_q   <= 1'b1;
              bus_we_q    <= is_store;
              bus_addr_q  <= addr_d;
              bus_be_q    <= be_d;
              bus_wdata_q <= wdata_d;
            end
          end
        end
        BUS: begin
          if (bus_ack || timeout_hit) begin
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            bus_be_q  <= '0;
            cnt_q     <= '0;
            // A cancelled access has no response to give, so it skips RESP
            // and the unit is ready again in the cycle after completion.
            if (cancel_q || flush) begin
              state_q  <= IDLE;
              cancel_q <= 1'b0;
            end else begin
              state_q        <= RESP;
              resp_valid_q   <= 1'b1;
              resp_exc_q     <= !bus_ack;
              resp_exccode_q <= bus_ack ? 5'd0 : 5'd7;
              resp_rdata_q   <= bus_ack ? ext_d : 32'd0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (flush) cancel_q <= 1'b1;
          end
        end
        RESP: begin
          state_q        <= IDLE;
          cancel_q       <= 1'b0;
          resp_exc_q     <= 1'b0;
          resp_exccode_q <= '0;
          resp_rdata_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == IDLE);
  // A flush arriving during the response cycle still kills the pulse.
  assign resp_valid   = resp_valid_q && !flush;
  assign resp_rdata   = resp_rdata_q;
  assign resp_exc     = resp_exc_q;
  assign resp_exccode = resp_exccode_q;
  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_be       = bus_be_q;
  assign bus_wdata    = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: 32-bit bus, TIMEOUT=3
  logic        a_req_valid, a_req_ready, a_flush, a_resp_valid, a_resp_exc;
  logic [3:0]  a_req_op;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic [4:0]  a_resp_exccode;
  logic        a_bus_req, a_bus_we, a_bus_ack;
  logic [31:0] a_bus_addr, a_bus_wdata, a_bus_rdata;
  logic [3:0]  a_bus_be;

  // Instance B: 64-bit bus, default TIMEOUT
  logic        b_req_valid, b_req_ready, b_flush, b_resp_valid, b_resp_exc;
  logic [3:0]  b_req_op;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic [4:0]  b_resp_exccode;
  logic        b_bus_req, b_bus_we, b_bus_ack;
  logic [31:0] b_bus_addr;
  logic [63:0] b_bus_wdata, b_bus_rdata;
  logic [7:0]  b_bus_be;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(3)) u_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_op(a_req_op), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .req_ready(a_req_ready), .flush(a_flush),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_exc(a_resp_exc),
    .resp_exccode(a_resp_exccode), .bus_req(a_bus_req), .bus_we(a_bus_we),
    .bus_addr(a_bus_addr), .bus_be(a_bus_be), .bus_wdata(a_bus_wdata),
    .bus_ack(a_bus_ack), .bus_rdata(a_bus_rdata)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_op(b_req_op), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_ready(b_req_ready), .flush(b_flush),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_exc(b_resp_exc),
    .resp_exccode(b_resp_exccode), .bus_req(b_bus_req), .bus_we(b_bus_we),
    .bus_addr(b_bus_addr), .bus_be(b_bus_be), .bus_wdata(b_bus_wdata),
    .bus_ack(b_bus_ack), .bus_rdata(b_bus_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Present one request to A for a single accept edge (cycle 0).
  task automatic a_issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
    a_req_valid = 1'b1; a_req_op = op; a_req_addr = addr; a_req_wdata = wd;
    nxt();
    a_req_valid = 1'b0; a_req_op = 4'd0;
  endtask

  initial begin
    reset = 1'b1;
    a_req_valid = 0; a_req_op = 0; a_req_addr = 0; a_req_wdata = 0; a_flush = 0;
    a_bus_ack = 0; a_bus_rdata = 0;
    b_req_valid = 0; b_req_op = 0; b_req_addr = 0; b_req_wdata = 0; b_flush = 0;
    b_bus_ack = 0; b_bus_rdata = 0;
    #1;
    chk("rst_bus_req", a_bus_req, 0);
    chk("rst_resp_valid", a_resp_valid, 0);
    chk("rst_bus_addr", a_bus_addr, 0);
    chk("rst_ready", a_req_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    nxt();

    // lb 0x1003, ack in cycle 2
    a_issue(4'd3, 32'h1003, 0);
    chk("lb_bus_req", a_bus_req, 1);
    chk("lb_bus_be", a_bus_be, 4'h0);
    chk("lb_bus_we", a_bus_we, 0);
    chk("lb_bus_addr", a_bus_addr, 32'h1000);
    chk("lb_busy", a_req_ready, 0);
    nxt();
    a_bus_ack = 1; a_bus_rdata = 32'h80FF_1234;
    chk("lb_no_resp_c2", a_resp_valid, 0);
    nxt();
    a_bus_ack = 0;
    chk("lb_resp_valid", a_resp_valid, 1);
    chk("lb_rdata", a_resp_rdata, 32'hFFFF_FF80);
    chk("lb_exc", a_resp_exc, 0);
    nxt();
    chk("lb_pulse_end", a_resp_valid, 0);
    chk("lb_ready", a_req_ready, 1);

    // lbu 0x1003, same data
    a_issue(4'd2, 32'h1003, 0);
    nxt();
    a_bus_ack = 1;
    nxt();
    a_bus_ack = 0;
    chk("lbu_resp_valid", a_resp_valid, 1);
    chk("lbu_rdata", a_resp_rdata, 32'h0000_0080);
    nxt();

    // lh 0x1002, ack in cycle 1: upper half 0x8001 sign-extended
    a_bus_rdata = 32'h8001_0000;
    a_issue(4'd5, 32'h1002, 0);
    a_bus_ack = 1;
    nxt();
    a_bus_ack = 0;
    chk("lh_resp_valid", a_resp_valid, 1);
    chk("lh_rdata", a_resp_rdata, 32'hFFFF_8001);
    nxt();

    // Misaligned lw / sh
    a_issue(4'd1, 32'h1001, 0);
    chk("adel_bus_req", a_bus_req, 0);
    chk("adel_resp_valid", a_resp_valid, 1);
    chk("adel_exc", a_resp_exc, 1);
    chk("adel_code", a_resp_exccode, 5'd4);
    chk("adel_rdata", a_resp_rdata, 0);
    nxt();
    chk("adel_pulse_end", a_resp_valid, 0);
    a_issue(4'd8, 32'h1001, 32'h1234);
    chk("ades_resp_valid", a_resp_valid, 1);
    chk("ades_code", a_resp_exccode, 5'd5);
    chk("ades_bus_req", a_bus_req, 0);
    nxt();

    // Ignored op and flush in IDLE
    a_issue(4'd9, 32'h1000, 0);
    chk("op9_ready", a_req_ready, 1);
    chk("op9_bus_req", a_bus_req, 0);
    a_flush = 1;
    a_issue(4'd1, 32'h1000, 0);
    a_flush = 0;
    chk("flush_idle_ready", a_req_ready, 1);
    chk("flush_idle_bus_req", a_bus_req, 0);

    // Timeout: lw with no ack
    a_issue(4'd1, 32'h1000, 0);
    chk("to_req_c1", a_bus_req, 1);
    nxt();
    chk("to_req_c2", a_bus_req, 1);
    nxt();
    chk("to_req_c3", a_bus_req, 1);
    nxt();
    chk("to_req_c4", a_bus_req, 0);
    chk("to_resp_valid", a_resp_valid, 1);
    chk("to_exc", a_resp_exc, 1);
    chk("to_code", a_resp_exccode, 5'd7);
    nxt();

    // Ack coinciding with the third BUS cycle wins over timeout
    a_issue(4'd1, 32'h1004, 0);
    nxt();
    nxt();
    a_bus_ack = 1; a_bus_rdata = 32'h1234_5678;
    nxt();
    a_bus_ack = 0;
    chk("ackwin_resp_valid", a_resp_valid, 1);
    chk("ackwin_exc", a_resp_exc, 0);
    chk("ackwin_code", a_resp_exccode, 0);
    chk("ackwin_rdata", a_resp_rdata, 32'h1234_5678);
    nxt();

    // Flush pulse during BUS on sw
    a_issue(4'd6, 32'h3004, 32'hCAFE_F00D);
    chk("sw_we", a_bus_we, 1);
    chk("sw_be", a_bus_be, 4'hF);
    chk("sw_wdata", a_bus_wdata, 32'hCAFE_F00D);
    chk("sw_addr", a_bus_addr, 32'h3004);
    a_flush = 1;
    nxt();
    a_flush = 0;
    chk("sw_held_req", a_bus_req, 1);
    chk("sw_held_wdata", a_bus_wdata, 32'hCAFE_F00D);
    a_bus_ack = 1;
    nxt();
    a_bus_ack = 0;
    chk("sw_flush_no_resp", a_resp_valid, 0);
    chk("sw_flush_ready", a_req_ready, 1);
    chk("sw_flush_bus_req", a_bus_req, 0);
    nxt();
    chk("sw_flush_no_resp2", a_resp_valid, 0);

    // sb at lane 1: one-hot byte enable, byte replicated
    a_issue(4'd7, 32'h3001, 32'h0000_00A5);
    chk("sb_be", a_bus_be, 4'b0010);
    chk("sb_wdata", a_bus_wdata, 32'hA5A5_A5A5);
    a_bus_ack = 1;
    nxt();
    a_bus_ack = 0;
    chk("sb_resp_valid", a_resp_valid, 1);
    chk("sb_rdata", a_resp_rdata, 0);
    nxt();

    // Reset mid-BUS
    a_issue(4'd1, 32'h1000, 0);
    chk("rstmid_req_before", a_bus_req, 1);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_bus_req", a_bus_req, 0);
    chk("rstmid_resp_valid", a_resp_valid, 0);
    #3 reset = 1'b0;
    nxt();
    chk("rstmid_ready", a_req_ready, 1);
    chk("rstmid_no_resp", a_resp_valid, 0);
    nxt();
    chk("rstmid_no_resp2", a_resp_valid, 0);

    // 64-bit bus: sh 0x2002
    b_req_valid = 1; b_req_op = 4'd8; b_req_addr = 32'h2002; b_req_wdata = 32'h0000_BEEF;
    nxt();
    b_req_valid = 0; b_req_op = 0;
    chk("b_sh_addr", b_bus_addr, 32'h2000);
    chk("b_sh_be", b_bus_be, 8'b0000_1100);
    chk("b_sh_wdata", b_bus_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
    chk("b_sh_we", b_bus_we, 1);
    b_bus_ack = 1;
    nxt();
    b_bus_ack = 0;
    chk("b_sh_resp_valid", b_resp_valid, 1);
    chk("b_sh_rdata", b_resp_rdata, 0);
    chk("b_sh_exc", b_resp_exc, 0);
    nxt();

    // 64-bit bus: lbu at lane 5
    b_req_valid = 1; b_req_op = 4'd2; b_req_addr = 32'h2005;
    nxt();
    b_req_valid = 0; b_req_op = 0;
    chk("b_lbu_addr", b_bus_addr, 32'h2000);
    b_bus_ack = 1; b_bus_rdata = 64'h0011_2233_4455_6677;
    nxt();
    b_bus_ack = 0;
    chk("b_lbu_resp_valid", b_resp_valid, 1);
    chk("b_lbu_rdata", b_resp_rdata, 32'h0000_0022);
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
